nvdla_hwpe_dbb_initiator: RTL and testbench
===========================================

# nvdla_hwpe_dbb_initiator

DBB initiator (master) bridge: turns a programmed HWPE job into NVDLA DBB write or read bursts. Write jobs pack the 32-bit HWPE input stream into wide DBB write beats. Read jobs unpack wide DBB read beats into the 32-bit HWPE output stream. It sits on the engine side, driving the DBB request/data channels that the hwpe-to-DBB responder bridge terminates.

## Interface
- `DBB_DW`, default 512: DBB data width; must be a multiple of 32. R = `DBB_DW`/32 words per beat.
- `AW`, default 64: DBB address width.
- `clk_i` in 1: clock, single domain.
- `rst_ni` in 1: reset, synchronous, active-low.
- `clear_i` in 1: synchronous soft clear.
- `start_i` in 1: job start pulse; sampled only in IDLE.
- `rnw_i` in 1: 1 = read job, 0 = write job.
- `addr_i` in AW: burst base address.
- `len_i` in 8: beat count, 1..255; 0 is illegal.
- `id_i` in 8: transaction ID.
- `busy_o` out 1: high when not in IDLE.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: sticky error; cleared by the next accepted start.
- `in_*` (sink, 32-bit data, 4-bit strb, valid/ready): write payload.
- `out_*` (source, 32-bit data, 4-bit strb = 4'hF, valid/ready): read payload.
- `wreq_valid_o`/`wreq_ready_i`, `wreq_addr_o` AW, `wreq_len_o` 8, `wreq_id_o` 8: write request.
- `wdat_valid_o`/`wdat_ready_i`, `wdat_data_o` DBB_DW, `wdat_strb_o` DBB_DW/8, `wdat_last_o`: write data.
- `wrsp_valid_i`/`wrsp_ready_o`, `wrsp_id_i` 8: write response.
- `rreq_valid_o`/`rreq_ready_i`, `rreq_addr_o`, `rreq_len_o`, `rreq_id_o`: read request.
- `rdat_valid_i`/`rdat_ready_o`, `rdat_data_i` DBB_DW, `rdat_id_i` 8, `rdat_last_i`: read data.

## Operation
- FSM states: IDLE, WREQ, WDATA, WRESP, RREQ, RDATA, DONE.
- IDLE + start_i:
  - len_i == 0: go to DONE with err_o set; no request is issued.
  - otherwise: latch addr/len/id; go to WREQ if rnw_i = 0, else RREQ.
- WREQ / RREQ: request valid held high with stable fields until ready. On handshake, go to WDATA / RDATA.
- WDATA, packing:
  - in_ready = 1 while the pack buffer is not full. Word k (0..R-1) of each beat lands at bits [32k+31:32k], strb at [4k+3:4k]. Word 0 is first, little-endian lane order.
  - After the R-th word, wdat_valid rises. in_ready stays 0 until wdat handshakes.
  - wdat_last = 1 on beat number len. After the last beat, go to WRESP.
- WRESP: wrsp_ready = 1. On wrsp_valid, go to DONE.
- RDATA, unpacking:
  - rdat_ready = 1 only while the unpack buffer is empty. The captured beat is emitted as R words, word 0 first.
  - The job ends when len beats have been drained, or after the drain of a beat with rdat_last = 1, whichever comes first. If the two disagree, set err_o.
- DONE: done_o pulses for one cycle; return to IDLE.
- Beat counter is 8-bit and counts 1..len; it never wraps.
- Word index is log2(R) bits and wraps R-1 → 0 per beat.

## Timing
- Reset or clear_i: state = IDLE, buffers and counters empty. All valid/ready outputs, busy_o, done_o and err_o read 0 from the next edge. clear_i/reset mid-burst abandons the job silently.
- All outputs are registered, except in_ready/rdat_ready/wrsp_ready, which are decoded from registered state only.
- Start-to-request latency: 1 cycle (start on edge n, request valid after edge n+1).
- Write throughput: R+1 cycles per beat with zero back-pressure. Read: 1 capture cycle + R word cycles per beat.
- Valid never drops before ready. Data and fields stay stable while valid & !ready.
- start_i while busy: ignored.
- wrsp_valid while not in WRESP: not accepted (ready = 0).

## Configuration
- `NVDLA_HWPE_DBB_INIT_ID_CHECK_EN` defined:
  - wrsp_id_i and every accepted rdat_id_i are compared with the latched ID.
  - On mismatch, err_o is set and the job still completes normally.
- Undefined: IDs are ignored and no comparator logic is built.

## Test plan
- Reset: hold rst_ni = 0 for 3 cycles mid-write, then release → all outputs 0, state IDLE, next start accepted.
- Write, DBB_DW = 512, len = 2, id = 0x5A, words 0..31 = 0x1000+k, wreq_ready delayed 3 cycles → two beats; beat 0 bits[31:0] = 0x1000, bits[511:480] = 0x100F; wdat_last only on beat 1; wrsp id 0x5A → done_o pulses once, err_o = 0.
- Read, len = 3, random rdat_valid and out_ready stalls → 48 words out in order, rdat_ready never high while words remain in the buffer.
- Read, len = 4, rdat_last asserted on beat 2 → job ends after 32 words, err_o = 1.
- start with len_i = 0 → no wreq/rreq asserted, done_o 2 cycles after start, err_o = 1.
- With macro defined: write id 0x11, wrsp_id 0x12 → err_o = 1, done_o pulses. Without macro: same stimulus → err_o = 0.

Source files
------------

// File: rtl/nvdla_hwpe_dbb_initiator.sv
// nvdla_hwpe_dbb_initiator
//
// Initiator (master) bridge between an HWPE engine and the NVDLA DBB
// channels. A job is programmed with start_i.
// - Write jobs pack the 32-bit in_* stream into DBB_DW-wide write beats.
// - Read jobs unpack DBB_DW-wide read beats into the 32-bit out_* stream.
//
// Ports
//   clk_i, rst_ni, clear_i       : clock, synchronous active-low reset, soft clear
//   start_i, rnw_i, addr_i,
//   len_i, id_i                  : job programming (len_i = beat count, 0 is illegal)
//   busy_o, done_o, err_o        : status (done_o is a one-cycle pulse, err_o is sticky)
//   in_*                         : 32-bit write payload sink
//   out_*                        : 32-bit read payload source (strb is always 4'hF)
//   wreq_*, wdat_*, wrsp_*       : DBB write request, write data and write response
//   rreq_*, rdat_*               : DBB read request and read data
//
// Optional feature: define NVDLA_HWPE_DBB_INIT_ID_CHECK_EN to compare wrsp_id_i
// and every accepted rdat_id_i against the job ID. A mismatch sets err_o and
// the job still completes.
module nvdla_hwpe_dbb_initiator #(
    parameter int unsigned DBB_DW = 512,
    parameter int unsigned AW     = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic                rnw_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [7:0]          len_i,
    input  logic [7:0]          id_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    input  logic [31:0]         in_data_i,
    input  logic [3:0]          in_strb_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [31:0]         out_data_o,
    output logic [3:0]          out_strb_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                wreq_valid_o,
    input  logic                wreq_ready_i,
    output logic [AW-1:0]       wreq_addr_o,
    output logic [7:0]          wreq_len_o,
    output logic [7:0]          wreq_id_o,
    output logic                wdat_valid_o,
    input  logic                wdat_ready_i,
    output logic [DBB_DW-1:0]   wdat_data_o,
    output logic [DBB_DW/8-1:0] wdat_strb_o,
    output logic                wdat_last_o,
    input  logic                wrsp_valid_i,
    output logic                wrsp_ready_o,
    input  logic [7:0]          wrsp_id_i,
    output logic                rreq_valid_o,
    input  logic                rreq_ready_i,
    output logic [AW-1:0]       rreq_addr_o,
    output logic [7:0]          rreq_len_o,
    output logic [7:0]          rreq_id_o,
    input  logic                rdat_valid_i,
    output logic                rdat_ready_o,
    input  logic [DBB_DW-1:0]   rdat_data_i,
    input  logic [7:0]          rdat_id_i,
    input  logic                rdat_last_i
);

    localparam int unsigned R    = DBB_DW / 32;
    localparam int unsigned IdxW = (R > 1) ? $clog2(R) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(R - 1);

    typedef enum logic [2:0] {
        StIdle, StWreq, StWdata, StWresp, StRreq, StRdata, StDone
    } state_e;

    state_e r_state, w_state_d;

    logic [AW-1:0]       r_addr;
    logic [7:0]          r_len;
    logic [7:0]          r_id;
    logic [7:0]          r_beat;
    logic [IdxW-1:0]     r_widx;
    logic [IdxW-1:0]     r_ridx;
    logic [DBB_DW-1:0]   r_buf;
    logic [DBB_DW/8-1:0] r_wstrb;
    logic                r_wreq_valid;
    logic                r_rreq_valid;
    logic                r_wdat_valid;
    logic                r_wdat_last;
    logic                r_rfull;
    logic                r_rlast;
    logic                r_out_valid;
    logic [31:0]         r_out_data;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic            w_start_acc;
    logic            w_wreq_hs;
    logic            w_rreq_hs;
    logic            w_in_hs;
    logic            w_wdat_hs;
    logic            w_wrsp_hs;
    logic            w_rdat_hs;
    logic            w_out_hs;
    logic            w_beat_is_len;
    logic            w_rbeat_end;
    logic            w_rjob_end;
    logic            w_wrsp_id_err;
    logic            w_rdat_id_err;
    logic [IdxW-1:0] w_ridx_nxt;

`ifdef NVDLA_HWPE_DBB_INIT_ID_CHECK_EN
    assign w_wrsp_id_err = (wrsp_id_i != r_id);
    assign w_rdat_id_err = (rdat_id_i != r_id);
`else
    logic w_unused_id;
    assign w_unused_id   = ^{wrsp_id_i, rdat_id_i};
    assign w_wrsp_id_err = 1'b0;
    assign w_rdat_id_err = 1'b0;
`endif

    // Ready outputs are decoded from registered state only.
    assign in_ready_o   = (r_state == StWdata) && !r_wdat_valid;
    assign wrsp_ready_o = (r_state == StWresp);
    assign rdat_ready_o = (r_state == StRdata) && !r_rfull;

    assign w_start_acc   = (r_state == StIdle) && start_i;
    assign w_wreq_hs     = r_wreq_valid && wreq_ready_i;
    assign w_rreq_hs     = r_rreq_valid && rreq_ready_i;
    assign w_in_hs       = in_valid_i && in_ready_o;
    assign w_wdat_hs     = r_wdat_valid && wdat_ready_i;
    assign w_wrsp_hs     = wrsp_valid_i && wrsp_ready_o;
    assign w_rdat_hs     = rdat_valid_i && rdat_ready_o;
    assign w_out_hs      = r_out_valid && out_ready_i;
    assign w_beat_is_len = (r_beat == r_len);
    assign w_ridx_nxt    = r_ridx + IdxW'(1);
    // A read job ends on draining the beat that hits len or carries rdat_last.
    assign w_rbeat_end   = w_out_hs && (r_ridx == LastIdx);
    assign w_rjob_end    = w_rbeat_end && (w_beat_is_len || r_rlast);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (start_i) begin
                    if (len_i == 8'd0) begin
                        w_state_d = StDone;
                    end else begin
                        w_state_d = rnw_i ? StRreq : StWreq;
                    end
                end
            end
            StWreq:  if (w_wreq_hs) w_state_d = StWdata;
            StWdata: if (w_wdat_hs && r_wdat_last) w_state_d = StWresp;
            StWresp: if (w_wrsp_hs) w_state_d = StDone;
            StRreq:  if (w_rreq_hs) w_state_d = StRdata;
            StRdata: if (w_rjob_end) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_addr       <= '0;
            r_len        <= '0;
            r_id         <= '0;
            r_beat       <= '0;
            r_widx       <= '0;
            r_ridx       <= '0;
            r_buf        <= '0;
            r_wstrb      <= '0;
            r_wreq_valid <= 1'b0;
            r_rreq_valid <= 1'b0;
            r_wdat_valid <= 1'b0;
            r_wdat_last  <= 1'b0;
            r_rfull      <= 1'b0;
            r_rlast      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_busy <= (w_state_d != StIdle);
            r_done <= (r_state == StDone);

            if (w_start_acc) begin
                r_err        <= (len_i == 8'd0);
                r_addr       <= addr_i;
                r_len        <= len_i;
                r_id         <= id_i;
                r_beat       <= 8'd1;
                r_widx       <= '0;
                r_ridx       <= '0;
                r_wreq_valid <= (len_i != 8'd0) && !rnw_i;
                r_rreq_valid <= (len_i != 8'd0) && rnw_i;
            end

            if (w_wreq_hs) r_wreq_valid <= 1'b0;
            if (w_rreq_hs) r_rreq_valid <= 1'b0;

            // Pack: word k of a beat goes to lane k; the R-th word closes the beat.
            if (w_in_hs) begin
                r_buf[32*r_widx +: 32]  <= in_data_i;
                r_wstrb[4*r_widx +: 4]  <= in_strb_i;
                if (r_widx == LastIdx) begin
                    r_widx       <= '0;
                    r_wdat_valid <= 1'b1;
                    r_wdat_last  <= w_beat_is_len;
                end else begin
                    r_widx <= r_widx + IdxW'(1);
                end
            end

            if (w_wdat_hs) begin
                r_wdat_valid <= 1'b0;
                r_wdat_last  <= 1'b0;
                if (!r_wdat_last) r_beat <= r_beat + 8'd1;
            end

            if (w_wrsp_hs && w_wrsp_id_err) r_err <= 1'b1;

            // Unpack: capture a whole beat, word 0 is presented immediately.
            if (w_rdat_hs) begin
                r_buf       <= rdat_data_i;
                r_rfull     <= 1'b1;
                r_rlast     <= rdat_last_i;
                r_ridx      <= '0;
                r_out_valid <= 1'b1;
                r_out_data  <= rdat_data_i[31:0];
                if (w_rdat_id_err) r_err <= 1'b1;
            end

            if (w_out_hs) begin
                if (r_ridx == LastIdx) begin
                    r_out_valid <= 1'b0;
                    r_rfull     <= 1'b0;
                    r_ridx      <= '0;
                    if (w_beat_is_len != r_rlast) r_err <= 1'b1;
                    if (!w_beat_is_len && !r_rlast) r_beat <= r_beat + 8'd1;
                end else begin
                    r_ridx     <= w_ridx_nxt;
                    r_out_data <= r_buf[32*w_ridx_nxt +: 32];
                end
            end
        end
    end

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign out_data_o   = r_out_data;
    assign out_strb_o   = 4'hF;
    assign out_valid_o  = r_out_valid;
    assign wreq_valid_o = r_wreq_valid;
    assign wreq_addr_o  = r_addr;
    assign wreq_len_o   = r_len;
    assign wreq_id_o    = r_id;
    assign wdat_valid_o = r_wdat_valid;
    assign wdat_data_o  = r_buf;
    assign wdat_strb_o  = r_wstrb;
    assign wdat_last_o  = r_wdat_last;
    assign rreq_valid_o = r_rreq_valid;
    assign rreq_addr_o  = r_addr;
    assign rreq_len_o   = r_len;
    assign rreq_id_o    = r_id;

endmodule

// File: tb/tb_nvdla_hwpe_dbb_initiator.sv
// tb_nvdla_hwpe_dbb_initiator
//
// Directed bench for nvdla_hwpe_dbb_initiator with DBB_DW = 512 (16 words per beat).
// Inputs are driven 1 time unit after the rising edge and outputs sampled there.
module tb_nvdla_hwpe_dbb_initiator;

    localparam int unsigned DW = 512;
    localparam int unsigned AW = 64;
    localparam int unsigned R  = DW / 32;

    logic            clk, rst_n, clear, start, rnw;
    logic [AW-1:0]   addr;
    logic [7:0]      len, id;
    logic            busy, done, err;
    logic [31:0]     in_data;
    logic [3:0]      in_strb;
    logic            in_valid, in_ready;
    logic [31:0]     out_data;
    logic [3:0]      out_strb;
    logic            out_valid, out_ready;
    logic            wreq_valid, wreq_ready;
    logic [AW-1:0]   wreq_addr;
    logic [7:0]      wreq_len, wreq_id;
    logic            wdat_valid, wdat_ready;
    logic [DW-1:0]   wdat_data;
    logic [DW/8-1:0] wdat_strb;
    logic            wdat_last;
    logic            wrsp_valid, wrsp_ready;
    logic [7:0]      wrsp_id;
    logic            rreq_valid, rreq_ready;
    logic [AW-1:0]   rreq_addr;
    logic [7:0]      rreq_len, rreq_id;
    logic            rdat_valid, rdat_ready;
    logic [DW-1:0]   rdat_data;
    logic [7:0]      rdat_id;
    logic            rdat_last;

    int n_vec;
    int n_err;

    nvdla_hwpe_dbb_initiator #(
        .DBB_DW (DW),
        .AW     (AW)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .start_i      (start),
        .rnw_i        (rnw),
        .addr_i       (addr),
        .len_i        (len),
        .id_i         (id),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .in_data_i    (in_data),
        .in_strb_i    (in_strb),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .out_data_o   (out_data),
        .out_strb_o   (out_strb),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .wreq_valid_o (wreq_valid),
        .wreq_ready_i (wreq_ready),
        .wreq_addr_o  (wreq_addr),
        .wreq_len_o   (wreq_len),
        .wreq_id_o    (wreq_id),
        .wdat_valid_o (wdat_valid),
        .wdat_ready_i (wdat_ready),
        .wdat_data_o  (wdat_data),
        .wdat_strb_o  (wdat_strb),
        .wdat_last_o  (wdat_last),
        .wrsp_valid_i (wrsp_valid),
        .wrsp_ready_o (wrsp_ready),
        .wrsp_id_i    (wrsp_id),
        .rreq_valid_o (rreq_valid),
        .rreq_ready_i (rreq_ready),
        .rreq_addr_o  (rreq_addr),
        .rreq_len_o   (rreq_len),
        .rreq_id_o    (rreq_id),
        .rdat_valid_i (rdat_valid),
        .rdat_ready_o (rdat_ready),
        .rdat_data_i  (rdat_data),
        .rdat_id_i    (rdat_id),
        .rdat_last_i  (rdat_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear      = 1'b0;
        start      = 1'b0;
        rnw        = 1'b0;
        addr       = '0;
        len        = '0;
        id         = '0;
        in_data    = '0;
        in_strb    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        wreq_ready = 1'b0;
        wdat_ready = 1'b0;
        wrsp_valid = 1'b0;
        wrsp_id    = '0;
        rreq_ready = 1'b0;
        rdat_valid = 1'b0;
        rdat_data  = '0;
        rdat_id    = '0;
        rdat_last  = 1'b0;
    endtask

    // Beat whose word k holds base + k.
    function automatic logic [DW-1:0] beat_of(input int unsigned base);
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < R; k++) v[32*k +: 32] = 32'(base + k);
        return v;
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_outs"},
                 {busy, done, err, in_ready, out_valid, wreq_valid, wdat_valid,
                  wrsp_ready, rreq_valid, rdat_ready}, '0);
    endtask

    task automatic do_write(input logic [7:0] l, input logic [7:0] tid, input logic [7:0] rsp_id,
                            input int req_delay, input logic exp_err);
        int   sent, beats, dones, wreq_hi, bad_rsp;
        logic wlast_seen, rsp_seen;
        start = 1'b1; rnw = 1'b0; addr = 64'h0000_0001_0000_0040; len = l; id = tid;
        step();
        start = 1'b0;
        check_eq("wr_req_valid", wreq_valid, 1'b1);
        check_eq("wr_req_fields", {wreq_addr, wreq_len, wreq_id}, {addr, l, tid});
        check_eq("wr_err_cleared", err, 1'b0);
        sent = 0; beats = 0; dones = 0; wreq_hi = 0; bad_rsp = 0;
        wlast_seen = 1'b0; rsp_seen = 1'b0;
        for (int cyc = 0; cyc < 400 && !(dones > 0 && !busy); cyc++) begin
            wreq_ready = (cyc >= req_delay);
            in_valid   = (sent < R * l);
            in_data    = 32'(32'h1000 + sent);
            in_strb    = 4'hF;
            wdat_ready = 1'b1;
            wrsp_valid = wlast_seen && !rsp_seen;
            wrsp_id    = rsp_id;
            if (wreq_valid) wreq_hi++;
            if (wrsp_ready && !wlast_seen) bad_rsp++;
            if (in_valid && in_ready) sent++;
            if (wdat_valid && wdat_ready) begin
                check_eq($sformatf("wr_beat%0d_data", beats), wdat_data,
                         beat_of(32'h1000 + R * beats));
                check_eq($sformatf("wr_beat%0d_strb", beats), wdat_strb, {(DW/8){1'b1}});
                check_eq($sformatf("wr_beat%0d_last", beats), wdat_last, (beats == l - 1));
                if (wdat_last) wlast_seen = 1'b1;
                beats++;
            end
            if (wrsp_valid && wrsp_ready) rsp_seen = 1'b1;
            if (done) dones++;
            step();
        end
        check_eq("wr_req_hold", wreq_hi, req_delay + 1);
        check_eq("wr_beats", beats, l);
        check_eq("wr_early_rsp_ready", bad_rsp, 0);
        check_eq("wr_done_pulses", dones, 1);
        check_eq("wr_done_low", done, 1'b0);
        check_eq("wr_err", err, exp_err);
        idle_inputs();
    endtask

    // nb_last: 1-based beat number on which the responder raises rdat_last.
    task automatic do_read(input logic [7:0] l, input int nb_last, input int exp_words,
                           input logic exp_err);
        int   sent, popped, viol, dones;
        logic rreq_seen, hs;
        start = 1'b1; rnw = 1'b1; addr = 64'h0000_0002_0000_0100; len = l; id = 8'h33;
        step();
        start = 1'b0;
        check_eq("rd_req_valid", {rreq_valid, wreq_valid}, 2'b10);
        check_eq("rd_req_fields", {rreq_addr, rreq_len, rreq_id}, {addr, l, 8'h33});
        sent = 0; popped = 0; viol = 0; dones = 0; rreq_seen = 1'b0;
        for (int cyc = 0; cyc < 3000 && !(dones > 0 && !busy); cyc++) begin
            rreq_ready = 1'b1;
            if (!rdat_valid && rreq_seen && sent < l) rdat_valid = ($urandom_range(0, 2) != 0);
            rdat_data = beat_of(32'h2000 + R * sent);
            rdat_last = (sent + 1 == nb_last);
            rdat_id   = 8'h33;
            out_ready = ($urandom_range(0, 3) != 0);
            hs = 1'b0;
            if (rdat_ready && (sent * R - popped) != 0) viol++;
            if (rreq_valid && rreq_ready) rreq_seen = 1'b1;
            if (out_valid && out_ready) begin
                check_eq($sformatf("rd_word%0d", popped), out_data, 32'(32'h2000 + popped));
                popped++;
            end
            if (rdat_valid && rdat_ready) begin
                sent++;
                hs = 1'b1;
            end
            if (done) dones++;
            step();
            if (hs) rdat_valid = 1'b0;
        end
        check_eq("rd_words", popped, exp_words);
        check_eq("rd_ready_while_full", viol, 0);
        check_eq("rd_done_pulses", dones, 1);
        check_eq("rd_strb", out_strb, 4'hF);
        check_eq("rd_err", err, exp_err);
        check_eq("rd_out_idle", out_valid, 1'b0);
        idle_inputs();
    endtask

    initial begin
        logic exp_id_err;
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check_quiet("reset");

        // Zero-length job: no request, done two cycles after start, err set.
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        check_eq("len0_t1", {wreq_valid, rreq_valid, done, busy}, 4'b0001);
        step();
        check_eq("len0_t2", {wreq_valid, rreq_valid, done, busy, err}, 5'b00101);
        step();
        check_eq("len0_t3", {done, err}, 2'b01);

        // Reset held for 3 cycles in the middle of a write.
        start = 1'b1; rnw = 1'b0; len = 8'd2; id = 8'h44;
        step();
        start = 1'b0; wreq_ready = 1'b1;
        step();
        wreq_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_0000; in_strb = 4'hF;
        repeat (5) step();
        rst_n = 1'b0;
        repeat (3) step();
        check_quiet("rst_hold");
        rst_n = 1'b1;
        idle_inputs();
        step();
        check_quiet("rst_mid");

        do_write(8'd2, 8'h5A, 8'h5A, 3, 1'b0);
        do_read(8'd3, 3, 48, 1'b0);
        do_read(8'd4, 2, 32, 1'b1);

`ifdef NVDLA_HWPE_DBB_INIT_ID_CHECK_EN
        exp_id_err = 1'b1;
`else
        exp_id_err = 1'b0;
`endif
        do_write(8'd1, 8'h11, 8'h12, 0, exp_id_err);

        // Soft clear in the middle of a read abandons the job.
        start = 1'b1; rnw = 1'b1; len = 8'd2; id = 8'h33;
        step();
        start = 1'b0; rreq_ready = 1'b1;
        step();
        rreq_ready = 1'b0; rdat_valid = 1'b1; rdat_data = beat_of(32'h3000); rdat_id = 8'h33;
        step();
        rdat_valid = 1'b0;
        check_eq("clr_word0", {out_valid, out_data}, {1'b1, 32'h3000});
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_quiet("clear");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
